// File: rtl/i2c_sync_data_fifo.sv
// Single-clock data FIFO for the I2C master datapath (TX/RX buffer).
// Fill level, thresholds, sticky errors, flush and optional first-word-fall-through.
module i2c_sync_data_fifo #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 4,
    parameter int FWFT     = 0
) (
    input  logic                i2c_core_clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                wr_en_i,
    input  logic [DATASIZE-1:0] wdata_i,
    input  logic                rd_en_i,
    output logic [DATASIZE-1:0] rdata_o,
    output logic                rvalid_o,
    input  logic [ADDRSIZE:0]   af_thresh_i,
    input  logic [ADDRSIZE:0]   ae_thresh_i,
    input  logic                err_clr_i,
    output logic [ADDRSIZE:0]   level_o,
    output logic                full_o,
    output logic                empty_o,
    output logic                almost_full_o,
    output logic                almost_empty_o,
    output logic                overflow_o,
    output logic                underflow_o,
    output logic [7:0]          status_o
);

    localparam int DEPTH = 2 ** ADDRSIZE;
    localparam logic [ADDRSIZE:0] DEPTH_L = (ADDRSIZE + 1)'(DEPTH);
    localparam logic [ADDRSIZE:0] ONE = (ADDRSIZE + 1)'(1);

    logic [DATASIZE-1:0] mem [DEPTH];
    logic [ADDRSIZE:0]   wptr;
    logic [ADDRSIZE:0]   rptr;
    logic [ADDRSIZE:0]   level;
    logic                ovf;
    logic                udf;
    logic                wr_ok;
    logic                rd_ok;

    assign full_o         = (level == DEPTH_L);
    assign empty_o        = (level == '0);
    assign almost_full_o  = (level >= af_thresh_i);
    assign almost_empty_o = (level <= ae_thresh_i);
    assign level_o        = level;
    assign overflow_o     = ovf;
    assign underflow_o    = udf;
    assign status_o = {empty_o, full_o, almost_empty_o, almost_full_o,
                       ovf, udf, 2'b00};

    assign wr_ok = wr_en_i && !full_o;
    assign rd_ok = rd_en_i && !empty_o;

    // Storage is deliberately not reset; validity is tracked by the pointers.
    always_ff @(posedge i2c_core_clk_i) begin
        if (!rst_i && !flush_i && wr_ok) begin
            mem[wptr[ADDRSIZE-1:0]] <= wdata_i;
        end
    end

    always_ff @(posedge i2c_core_clk_i) begin
        if (rst_i) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else if (flush_i) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + ONE;
            end
            if (rd_ok) begin
                rptr <= rptr + ONE;
            end
            unique case ({wr_ok, rd_ok})
                2'b10:   level <= level + ONE;
                2'b01:   level <= level - ONE;
                default: level <= level;
            endcase
            // A new error in the same cycle as a clear must not be lost.
            if (wr_en_i && full_o) begin
                ovf <= 1'b1;
            end else if (err_clr_i) begin
                ovf <= 1'b0;
            end
            if (rd_en_i && empty_o) begin
                udf <= 1'b1;
            end else if (err_clr_i) begin
                udf <= 1'b0;
            end
        end
    end

    if (FWFT == 0) begin : g_reg_read
        logic [DATASIZE-1:0] rd_q;
        logic                rv_q;

        always_ff @(posedge i2c_core_clk_i) begin
            if (rst_i || flush_i) begin
                rd_q <= '0;
                rv_q <= 1'b0;
            end else begin
                rv_q <= rd_ok;
                if (rd_ok) begin
                    rd_q <= mem[rptr[ADDRSIZE-1:0]];
                end
            end
        end

        assign rdata_o  = rd_q;
        assign rvalid_o = rv_q;
    end else begin : g_fwft_read
        assign rdata_o  = empty_o ? '0 : mem[rptr[ADDRSIZE-1:0]];
        assign rvalid_o = !empty_o;
    end

endmodule

// File: tb/tb_i2c_sync_data_fifo.sv
// Bench for i2c_sync_data_fifo: a registered-read and an FWFT instance share
// stimulus and are checked every cycle against a queue-based model.
module tb_i2c_sync_data_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       rd = 1'b0;
    logic       clr = 1'b0;
    logic [4:0] af_th = 5'd14;
    logic [4:0] ae_th = 5'd2;

    logic [7:0] r0_rdata, r1_rdata;
    logic       r0_rvalid, r1_rvalid;
    logic [4:0] r0_level, r1_level;
    logic       r0_full, r1_full, r0_empty, r1_empty;
    logic       r0_af, r1_af, r0_ae, r1_ae;
    logic       r0_ovf, r1_ovf, r0_udf, r1_udf;
    logic [7:0] r0_status, r1_status;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // model state
    logic [7:0] q[$];
    logic       m_ovf = 1'b0;
    logic       m_udf = 1'b0;
    logic [7:0] m_rdata = 8'h00;
    logic       m_rvalid = 1'b0;

    always #5 clk = ~clk;

    i2c_sync_data_fifo #(.DATASIZE(8), .ADDRSIZE(4), .FWFT(0)) u0 (
        .i2c_core_clk_i(clk), .rst_i(rst), .flush_i(flush),
        .wr_en_i(wr), .wdata_i(wdata), .rd_en_i(rd),
        .rdata_o(r0_rdata), .rvalid_o(r0_rvalid),
        .af_thresh_i(af_th), .ae_thresh_i(ae_th), .err_clr_i(clr),
        .level_o(r0_level), .full_o(r0_full), .empty_o(r0_empty),
        .almost_full_o(r0_af), .almost_empty_o(r0_ae),
        .overflow_o(r0_ovf), .underflow_o(r0_udf), .status_o(r0_status)
    );

    i2c_sync_data_fifo #(.DATASIZE(8), .ADDRSIZE(4), .FWFT(1)) u1 (
        .i2c_core_clk_i(clk), .rst_i(rst), .flush_i(flush),
        .wr_en_i(wr), .wdata_i(wdata), .rd_en_i(rd),
        .rdata_o(r1_rdata), .rvalid_o(r1_rvalid),
        .af_thresh_i(af_th), .ae_thresh_i(ae_th), .err_clr_i(clr),
        .level_o(r1_level), .full_o(r1_full), .empty_o(r1_empty),
        .almost_full_o(r1_af), .almost_empty_o(r1_ae),
        .overflow_o(r1_ovf), .underflow_o(r1_udf), .status_o(r1_status)
    );

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of stored words plus sticky flags.
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
            m_rdata = 8'h00;
            m_rvalid = 1'b0;
        end else if (flush) begin
            q.delete();
            m_rdata = 8'h00;
            m_rvalid = 1'b0;
        end else begin
            bit was_full, was_empty;
            was_full = (q.size() == 16);
            was_empty = (q.size() == 0);
            if (wr && was_full) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
            if (rd && was_empty) m_udf = 1'b1;
            else if (clr) m_udf = 1'b0;
            m_rvalid = rd && !was_empty;
            if (rd && !was_empty) m_rdata = q.pop_front();
            if (wr && !was_full) q.push_back(wdata);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int lv;
            logic e, f, a_f, a_e;
            logic [7:0] st, head;
            lv = q.size();
            e = (lv == 0);
            f = (lv == 16);
            a_f = (lv >= int'(af_th));
            a_e = (lv <= int'(ae_th));
            st = {e, f, a_e, a_f, m_ovf, m_udf, 2'b00};
            head = e ? 8'h00 : q[0];
            chk("m_level0", r0_level, lv);
            chk("m_level1", r1_level, lv);
            chk("m_status0", r0_status, st);
            chk("m_status1", r1_status, st);
            chk("m_flags0", {r0_empty, r0_full, r0_ae, r0_af, r0_ovf, r0_udf},
                {e, f, a_e, a_f, m_ovf, m_udf});
            chk("m_flags1", {r1_empty, r1_full, r1_ae, r1_af, r1_ovf, r1_udf},
                {e, f, a_e, a_f, m_ovf, m_udf});
            chk("m_rvalid0", r0_rvalid, m_rvalid);
            if (m_rvalid || chk_en) chk("m_rdata0", r0_rdata, m_rdata);
            chk("m_rvalid1", r1_rvalid, !e);
            chk("m_rdata1", r1_rdata, head);
        end
    end

    task automatic cyc(bit w, logic [7:0] d, bit r, bit f = 1'b0, bit c = 1'b0);
        wr = w;
        wdata = d;
        rd = r;
        flush = f;
        clr = c;
        @(posedge clk);
        #2;
        wr = 1'b0;
        rd = 1'b0;
        flush = 1'b0;
        clr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #2;
        chk_en = 1'b1;
        rst = 1'b0;
    endtask

    initial begin
        // reset state
        do_reset();
        chk("rst_level", r0_level, 0);
        chk("rst_empty", r0_empty, 1);
        chk("rst_full", r0_full, 0);
        chk("rst_rdata", r0_rdata, 8'h00);
        chk("rst_rvalid", r0_rvalid, 0);
        chk("rst_status", r0_status, 8'b1010_0000);

        // 1: fill to full, then overflow
        for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0);
        chk("t1_level", r0_level, 16);
        chk("t1_full", r0_full, 1);
        chk("t1_status6", r0_status[6], 1);
        chk("t1_fwft_head", r1_rdata, 8'h00);
        cyc(1, 8'h10, 0);
        chk("t1_ovf", r0_ovf, 1);
        chk("t1_level_hold", r0_level, 16);

        // 2: drain with registered read, then underflow
        for (int i = 0; i < 16; i++) begin
            cyc(0, 8'h00, 1);
            chk("t2_rdata", r0_rdata, i);
            chk("t2_rvalid", r0_rvalid, 1);
        end
        cyc(0, 8'h00, 0);
        chk("t2_rvalid_drop", r0_rvalid, 0);
        chk("t2_rdata_hold", r0_rdata, 8'h0F);
        cyc(0, 8'h00, 1);
        chk("t2_udf", r0_udf, 1);
        chk("t2_rdata_udf", r0_rdata, 8'h0F);
        chk("t2_rvalid_udf", r0_rvalid, 0);

        // 3: simultaneous write/read at level 8 with pointer wrap
        do_reset();
        for (int i = 0; i < 16; i++) cyc(1, 8'(8'h20 + i), 0);
        for (int i = 0; i < 8; i++) cyc(0, 8'h00, 1);
        chk("t3_level8", r0_level, 8);
        cyc(1, 8'hAA, 1);
        chk("t3_level_same", r0_level, 8);
        chk("t3_rdata_rw", r0_rdata, 8'h28);
        for (int k = 0; k < 8; k++) begin
            cyc(0, 8'h00, 1);
            if (k == 6) chk("t3_rdata_last_old", r0_rdata, 8'h2F);
        end
        chk("t3_rdata_aa", r0_rdata, 8'hAA);
        chk("t3_empty", r0_empty, 1);

        // 4: thresholds across the full range
        do_reset();
        af_th = 5'd12;
        ae_th = 5'd3;
        #1;
        for (int lvl = 0; lvl <= 16; lvl++) begin
            chk("t4_ae", r0_ae, (lvl <= 3));
            chk("t4_af", r0_af, (lvl >= 12));
            if (lvl < 16) cyc(1, 8'(lvl), 0);
        end
        af_th = 5'd14;
        ae_th = 5'd2;

        // 5: flush behaviour and error clearing
        do_reset();
        for (int i = 0; i < 17; i++) cyc(1, 8'(8'h40 + i), 0);
        cyc(0, 8'h00, 1);
        chk("t5_rdata_pre", r0_rdata, 8'h40);
        cyc(0, 8'h00, 1, 1);
        chk("t5_flush_rdata", r0_rdata, 8'h00);
        chk("t5_flush_rvalid", r0_rvalid, 0);
        chk("t5_flush_level", r0_level, 0);
        cyc(0, 8'h00, 1, 1);
        chk("t5_flush_no_udf", r0_udf, 0);
        for (int i = 0; i < 5; i++) cyc(1, 8'(8'h50 + i), 0);
        chk("t5_level5", r0_level, 5);
        chk("t5_ovf_kept", r0_ovf, 1);
        cyc(1, 8'h77, 0, 1);
        chk("t5_level0", r0_level, 0);
        chk("t5_empty", r0_empty, 1);
        chk("t5_ovf_after_flush", r0_ovf, 1);
        cyc(0, 8'h00, 0, 0, 1);
        chk("t5_ovf_clr", r0_ovf, 0);
        for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0);
        cyc(1, 8'h99, 0, 0, 1);
        chk("t5_set_wins", r0_ovf, 1);

        // 6: FWFT presentation
        do_reset();
        cyc(1, 8'h5C, 0);
        chk("t6_rvalid", r1_rvalid, 1);
        chk("t6_rdata", r1_rdata, 8'h5C);
        chk("t6_reg_rvalid", r0_rvalid, 0);
        cyc(0, 8'h00, 1);
        chk("t6_empty", r1_empty, 1);
        chk("t6_rdata0", r1_rdata, 8'h00);
        chk("t6_rvalid0", r1_rvalid, 0);
        chk("t6_reg_rdata", r0_rdata, 8'h5C);
        cyc(0, 8'h00, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
